efb_wb_arbiter: RTL
===================

// Module: efb_wb_arbiter
// PURPOSE
//  Two-master Wishbone arbiter that shares the single EFB Wishbone slave port (I2C/SPI hard IP)
//  between the LM8 passthru port (m0) and a hardware requester (m1, e.g. autonomous temp poller).
//  Grants are held for a whole cyc tenure so multi-access I2C/SPI register sequences are atomic.
//  A watchdog ends hung accesses with err. Sits between mico8/poller and myEFB, on sys_clk.
// PARAMETERS
//  ADR_W    8   Wishbone address width (EFB register map)
//  DAT_W    8   Wishbone data width
//  TIMEOUT  64  cycles of stb-without-ack before err; 0 disables watchdog
// PORTS
//  wb_clk_i      in   1      system clock (sys_clk)
//  rst_n         in   1      asynchronous, active-low reset
//  m0_cyc_i/m0_stb_i/m0_we_i  in  1 each  master 0 (LM8) controls
//  m0_adr_i      in   ADR_W  master 0 address
//  m0_dat_i      in   DAT_W  master 0 write data
//  m0_dat_o      out  DAT_W  read data to master 0
//  m0_ack_o      out  1      ack to master 0
//  m0_err_o      out  1      watchdog error to master 0
//  m1_*          same set as m0_* for master 1 (hardware requester)
//  s_cyc_o/s_stb_o/s_we_o     out 1 each  to EFB
//  s_adr_o       out  ADR_W  to EFB
//  s_dat_o       out  DAT_W  write data to EFB
//  s_dat_i       in   DAT_W  read data from EFB
//  s_ack_i       in   1      ack from EFB
//  gnt_o         out  2      one-hot current grant {m1,m0}; 00 = idle
// BEHAVIOUR
//  Reset: state IDLE, gnt_o=00, last=m1 (m0 wins first tie), s_cyc/stb/we=0, s_adr/s_dat=0,
//   all m*_ack/err=0, m*_dat_o=0, watchdog count=0. Reset mid-access aborts it; no ack issued.
//  FSM IDLE/G0/G1, registered grant. IDLE: m0_cyc only->G0; m1_cyc only->G1; both->master != last.
//  Request-to-grant latency 1 cycle; s_* outputs are muxed combinationally from the grant register.
//  G0/G1: held while granted cyc=1. Granted cyc=0: other cyc=1 -> switch directly (0 idle cycles),
//   else IDLE. last updated on every grant entry. Non-granted master's cyc/stb never reach EFB.
//  Ack/err/dat_o routed only to granted master; non-granted m*_ack/err=0, m*_dat_o=0.
//  In IDLE s_cyc=s_stb=0 regardless of inputs.
//  Watchdog: counter increments each cycle granted stb=1 and s_ack_i=0; clears on ack, on stb=0,
//   on grant change. At count==TIMEOUT-1: pulse err to granted master 1 cycle, force s_cyc=s_stb=0
//   that cycle, clear count; grant kept (master decides to drop cyc). ack and err never both high.
//  s_ack_i arriving while IDLE or on the switch cycle is discarded (not forwarded).
//  Counter width clog2(TIMEOUT+1), saturating never needed (cleared at limit).
// STRUCTURE
//  Shared include efb_arb_defs.vh: state encodings ST_IDLE/ST_G0/ST_G1, grant one-hot constants.
//  One sub-module: efb_arb_watchdog (count/clear/expire pulse, TIMEOUT param); arbiter FSM + muxes top.
// TESTING
//  m0 single write adr 8'h4A dat 8'h80, EFB ack after 2 cycles -> s_stb 1 cycle after m0_stb, m0_ack 1 pulse, gnt_o=01.
//  m0 & m1 cyc same cycle after reset -> m0 granted first; m0 drops cyc -> gnt_o 01->10 next cycle, no idle gap.
//  m1 holds cyc over 3 accesses while m0 requests -> m0 waits; s_adr only m1 addresses until m1 cyc=0.
//  Slave never acks, TIMEOUT=64 -> m*_err_o pulses on 64th stb cycle, s_stb low that cycle, m*_ack_o stays 0.
//  Read on m1 with s_dat_i=8'hA5 -> m1_dat_o=8'hA5 on ack, m0_dat_o=0, m0_ack_o=0.
//  rst_n low mid-access (stb=1, no ack) -> gnt_o=00, s_cyc=0 immediately; stray s_ack_i after release ignored.

Source files
------------

// File: rtl/efb_wb_arbiter_pkg.sv
// Shared encodings for the EFB Wishbone arbiter: FSM states, one-hot grant codes
// and the small helpers that translate between them.
package efb_wb_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_G0   = 2'd1;
    localparam logic [1:0] ST_G1   = 2'd2;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    localparam logic LAST_M0 = 1'b0;
    localparam logic LAST_M1 = 1'b1;

    function automatic logic [1:0] state_to_gnt(input logic [1:0] st);
        case (st)
            ST_G0:   return GNT_M0;
            ST_G1:   return GNT_M1;
            default: return GNT_NONE;
        endcase
    endfunction

    // Tie-break from IDLE: the master that was not granted last goes first.
    function automatic logic [1:0] idle_pick(input logic cyc0, input logic cyc1,
                                             input logic last);
        if (cyc0 && cyc1) begin
            return (last == LAST_M1) ? ST_G0 : ST_G1;
        end else if (cyc0) begin
            return ST_G0;
        end else if (cyc1) begin
            return ST_G1;
        end
        return ST_IDLE;
    endfunction

endpackage

// File: rtl/efb_arb_watchdog.sv
// Stall watchdog: counts consecutive strobe cycles without ack and pulses
// expire_o on the TIMEOUT-th one. TIMEOUT=0 disables it.
module efb_arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic active_i,
    input  logic ack_i,
    input  logic gnt_chg_i,
    output logic expire_o
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LIMIT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Expiry does not look at ack so the forced stb drop never depends on the slave.
    always_comb begin
        expire_o = (TIMEOUT != 0) && active_i && (cnt_q == LIMIT_C);
    end

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if ((TIMEOUT == 0) || gnt_chg_i || !active_i || ack_i || expire_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/efb_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the EFB slave port. Grants last a whole
// cyc tenure so multi-access I2C/SPI sequences stay atomic; a watchdog ends hung accesses.
module efb_wb_arbiter
    import efb_wb_arbiter_pkg::*;
#(
    parameter int ADR_W   = 8,
    parameter int DAT_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             wb_clk_i,
    input  logic             rst_n,

    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    output logic [DAT_W-1:0] m0_dat_o,
    output logic             m0_ack_o,
    output logic             m0_err_o,

    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    output logic [DAT_W-1:0] m1_dat_o,
    output logic             m1_ack_o,
    output logic             m1_err_o,

    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [DAT_W-1:0] s_dat_o,
    input  logic [DAT_W-1:0] s_dat_i,
    input  logic             s_ack_i,

    output logic [1:0]       gnt_o
);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             last_q;
    logic             last_d;

    logic             g0;
    logic             g1;
    logic             gnt_cyc;
    logic             gnt_stb;
    logic             gnt_we;
    logic [ADR_W-1:0] gnt_adr;
    logic [DAT_W-1:0] gnt_dat;
    logic             gnt_chg;
    logic             wd_expire;
    logic             ack_fwd;

    // Grant FSM: hold while the owner keeps cyc, hand over directly when it drops.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = idle_pick(m0_cyc_i, m1_cyc_i, last_q);
            ST_G0: begin
                if (!m0_cyc_i) begin
                    state_d = m1_cyc_i ? ST_G1 : ST_IDLE;
                end
            end
            ST_G1: begin
                if (!m1_cyc_i) begin
                    state_d = m0_cyc_i ? ST_G0 : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if ((state_d == ST_G0) && (state_q != ST_G0)) begin
            last_d = LAST_M0;
        end else if ((state_d == ST_G1) && (state_q != ST_G1)) begin
            last_d = LAST_M1;
        end
    end

    always_comb begin
        gnt_chg = (state_d != state_q);
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= LAST_M1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Request mux driven purely by the registered grant.
    always_comb begin
        g0      = (state_q == ST_G0);
        g1      = (state_q == ST_G1);
        gnt_cyc = 1'b0;
        gnt_stb = 1'b0;
        gnt_we  = 1'b0;
        gnt_adr = '0;
        gnt_dat = '0;
        if (g0) begin
            gnt_cyc = m0_cyc_i;
            gnt_stb = m0_cyc_i & m0_stb_i;
            gnt_we  = m0_we_i;
            gnt_adr = m0_adr_i;
            gnt_dat = m0_dat_i;
        end else if (g1) begin
            gnt_cyc = m1_cyc_i;
            gnt_stb = m1_cyc_i & m1_stb_i;
            gnt_we  = m1_we_i;
            gnt_adr = m1_adr_i;
            gnt_dat = m1_dat_i;
        end
    end

    efb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i     (wb_clk_i),
        .rst_n     (rst_n),
        .active_i  (gnt_stb),
        .ack_i     (s_ack_i),
        .gnt_chg_i (gnt_chg),
        .expire_o  (wd_expire)
    );

    // An ack only counts while the owner's strobe is actually out on the bus;
    // anything else (idle, hand-over cycle, expiry cycle) is a stray and dropped.
    always_comb begin
        ack_fwd = s_ack_i & gnt_stb & ~wd_expire;
    end

    always_comb begin
        s_cyc_o = gnt_cyc & ~wd_expire;
        s_stb_o = gnt_stb & ~wd_expire;
        s_we_o  = gnt_we;
        s_adr_o = gnt_adr;
        s_dat_o = gnt_dat;
    end

    always_comb begin
        m0_ack_o = g0 & ack_fwd;
        m0_err_o = g0 & wd_expire;
        m0_dat_o = g0 ? s_dat_i : '0;
        m1_ack_o = g1 & ack_fwd;
        m1_err_o = g1 & wd_expire;
        m1_dat_o = g1 ? s_dat_i : '0;
        gnt_o    = state_to_gnt(state_q);
    end

endmodule
